fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Multi-cycle fetch/commit controller that sequences the program-counter register (PC + 4 / PC + ImmOp mux and register) in the reduced RISC-V core.
- Fetches each instruction from instruction memory over a req/ack handshake with variable latency.
- Presents the instruction to decode over a valid/ready handshake, then waits for branch resolution when required.
- Issues exactly one PC-advance pulse (pc_en) per instruction, with the branch-select (pc_src).

Parameters:
- DATA_WIDTH, 32, instruction width.
- TIMEOUT, 15, max cycles in FETCH without imem_ack before fault. Used only with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  fetch request to instruction memory at current PC.
- imem_ack  in  1  memory has valid imem_rdata this cycle.
- imem_rdata  in  DATA_WIDTH  fetched instruction word.
- instr  out  DATA_WIDTH  registered instruction to decode.
- instr_valid  out  1  instr is valid for decode.
- instr_ready  in  1  decode accepts instr.
- is_branch  in  1  decode flag for instr; sampled only on the ISSUE handshake.
- br_valid  in  1  execute has resolved the branch.
- br_taken  in  1  branch outcome; sampled only with br_valid in RESOLVE.
- pc_en  out  1  one-cycle PC update enable to the PC register.
- pc_src  out  1  PC mux select: 1 = PC + ImmOp, 0 = PC + 4.
- state_o  out  3  current state encoding for debug: IDLE=0, FETCH=1, ISSUE=2, RESOLVE=3, UPDATE=4, HALT=5.
- fault  out  1  sticky fetch-timeout flag.

Behaviour:
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.
- Reset (rst high at posedge) takes effect on the next cycle:
  - state=IDLE; imem_req=0, instr_valid=0, pc_en=0, pc_src=0, instr=0, fault=0, taken latch=0, timeout counter=0.
  - Reset mid-operation aborts any outstanding fetch; a late imem_ack is ignored.
- IDLE: all outputs inactive. Unconditionally goes to FETCH next cycle, giving a one-cycle bubble after reset.
- FETCH: imem_req=1.
  - On imem_ack: instr <= imem_rdata; go to ISSUE.
  - Ack in the first FETCH cycle is legal (zero wait states).
  - imem_ack in any other state is ignored.
- ISSUE: instr_valid=1; instr is held stable until the handshake.
  - On instr_valid && instr_ready: if is_branch, go to RESOLVE; else taken latch <= 0, go to UPDATE.
  - Without instr_ready, stay in ISSUE indefinitely.
- RESOLVE: wait for br_valid, then taken latch <= br_taken and go to UPDATE.
  - br_valid outside RESOLVE is ignored, including the ISSUE handshake cycle.
- UPDATE: pc_en=1 for exactly one cycle; pc_src=taken latch; then go to FETCH.
  - The PC register loads at the end of UPDATE, so the next FETCH uses the new PC.
- pc_src is 0 in every cycle where pc_en is 0.
- pc_en is never asserted twice for one instruction.
- Minimum cycles per instruction (ack, ready and br_valid all immediate):
  - non-branch: 3 (FETCH, ISSUE, UPDATE).
  - branch: 4 (FETCH, ISSUE, RESOLVE, UPDATE).
- HALT: reachable only with FETCH_TIMEOUT_EN. All handshake outputs stay 0 and fault=1. Exited only by rst.
- Unused or illegal state encodings recover to IDLE on the next cycle.

Optional Feature:
- FETCH_TIMEOUT_EN defined:
  - A saturating counter, sized to hold TIMEOUT, clears on entry to FETCH and increments each FETCH cycle without imem_ack.
  - If the counter reaches TIMEOUT with no ack, go to HALT. imem_req drops and fault sets the next cycle.
  - An ack in the same cycle the counter reaches TIMEOUT wins: normal transition to ISSUE.
- Not defined: no counter; FETCH waits indefinitely; fault tied to 0; HALT is unreachable.

Test Plan:
- Reset, then non-branch stream:
  - Stimulus: rst 2 cycles; ack, ready and is_branch=0 immediate.
  - Response: state 0,1,2,4,1,2,4…; pc_en pulses every 3rd cycle with pc_src=0; instr equals each imem_rdata.
- Branch taken vs not taken:
  - Stimulus: is_branch=1, br_valid 3 cycles after entering RESOLVE, br_taken=1, then again with br_taken=0.
  - Response: each pc_en pulse lasts exactly one cycle, with pc_src=1 then pc_src=0; no pc_en during RESOLVE.
- Backpressure and memory latency:
  - Stimulus: imem_ack after 5 cycles; instr_ready low 4 cycles.
  - Response: imem_req high 5 cycles; instr held constant while instr_valid waits; a single pc_en per instruction.
- Spurious inputs:
  - Stimulus: imem_ack pulsed in ISSUE; br_valid pulsed in FETCH and in the ISSUE handshake cycle.
  - Response: no state change, instr unchanged, no extra pc_en.
- Reset mid-operation:
  - Stimulus: rst asserted in RESOLVE; imem_ack arrives in the cycle after rst.
  - Response: state IDLE, all outputs 0, ack ignored, FETCH resumes 1 cycle after rst release.
- FETCH_TIMEOUT_EN with TIMEOUT=15:
  - Stimulus: withhold imem_ack.
  - Response: after 15 FETCH cycles state=5, fault=1, imem_req=0; ack at cycle 15 instead gives ISSUE with fault=0; rst clears fault.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch/issue/resolve/update controller driving the PC register enable and mux select.
// Optional FETCH_TIMEOUT_EN adds a fetch watchdog that parks the sequencer in HALT.
module fetch_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  is_branch,
  input  logic                  br_valid,
  input  logic                  br_taken,
  output logic                  pc_en,
  output logic                  pc_src,
  output logic [2:0]            state_o,
  output logic                  fault
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_ISSUE   = 3'd2;
  localparam logic [2:0] S_RESOLVE = 3'd3;
  localparam logic [2:0] S_UPDATE  = 3'd4;
  localparam logic [2:0] S_HALT    = 3'd5;

  logic [2:0] state;
  logic [2:0] state_nx;
  logic       taken;
  logic       expired;

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Cleared outside FETCH so every fetch starts a fresh window.
  always_ff @(posedge clk) begin
    if (rst || state != S_FETCH) begin
      cnt <= '0;
    end else if (!imem_ack && cnt != CW'(TIMEOUT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = (cnt == CW'(TIMEOUT - 1));
  assign fault   = (state == S_HALT);
`else
  assign expired = 1'b0;
  assign fault   = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_nx = S_ISSUE;
        end else if (expired) begin
          state_nx = S_HALT;
        end
      end
      S_ISSUE: begin
        if (instr_ready) begin
          state_nx = is_branch ? S_RESOLVE : S_UPDATE;
        end
      end
      S_RESOLVE: begin
        if (br_valid) begin
          state_nx = S_UPDATE;
        end
      end
      S_UPDATE: state_nx = S_FETCH;
      S_HALT: begin
`ifdef FETCH_TIMEOUT_EN
        state_nx = S_HALT;
`else
        state_nx = S_IDLE;
`endif
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      instr <= '0;
      taken <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ack) begin
        instr <= imem_rdata;
      end
      if (state == S_ISSUE && instr_ready && !is_branch) begin
        taken <= 1'b0;
      end
      if (state == S_RESOLVE && br_valid) begin
        taken <= br_taken;
      end
    end
  end

  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_ISSUE);
  assign pc_en       = (state == S_UPDATE);
  assign pc_src      = pc_en & taken;
  assign state_o     = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer; timeout scenario selected by FETCH_TIMEOUT_EN.
// Inputs change on the falling edge, outputs are sampled there too.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        is_branch = 1'b0;
  logic        br_valid = 1'b0;
  logic        br_taken = 1'b0;
  logic        pc_en;
  logic        pc_src;
  logic [2:0]  state_o;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] sb_instr[$];
  logic        sb_src[$];

  int          o_req, o_bad, o_cyc, o_early, o_pen;
  logic        o_src, o_stable;
  logic [31:0] o_instr;
  logic [2:0]  o_next;

  fetch_sequencer #(.DATA_WIDTH(32), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .is_branch(is_branch), .br_valid(br_valid), .br_taken(br_taken),
    .pc_en(pc_en), .pc_src(pc_src), .state_o(state_o), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one instruction from FETCH to the next FETCH and records what was seen.
  task automatic drive_instr(input logic [31:0] d, input int ad, input int rd,
                             input bit br, input int bd, input bit tk, input bit spur);
    logic [31:0] first;
    o_req = 0; o_bad = 0; o_cyc = 0; o_early = 0; o_pen = 0;
    o_src = 1'b0; o_stable = 1'b1;
    sb_instr.push_back(d);
    sb_src.push_back(br & tk);
    for (int w = 0; w < 4 && state_o !== 3'd1; w++) @(negedge clk);
    for (int i = 0; i <= ad; i++) begin
      o_cyc++;
      if (state_o !== 3'd1) o_bad++;
      if (imem_req === 1'b1) o_req++;
      if (pc_en !== 1'b0 || pc_src !== 1'b0) o_early++;
      imem_ack   = (i == ad);
      imem_rdata = (i == ad) ? d : $urandom;
      br_valid   = spur && (i != ad);
      br_taken   = 1'b1;
      @(negedge clk);
    end
    imem_ack = 1'b0;
    br_valid = 1'b0;
    first = instr;
    for (int j = 0; j <= rd; j++) begin
      o_cyc++;
      if (state_o !== 3'd2 || instr_valid !== 1'b1) o_bad++;
      if (instr !== first) o_stable = 1'b0;
      if (pc_en !== 1'b0 || pc_src !== 1'b0) o_early++;
      instr_ready = (j == rd);
      is_branch   = (j == rd) ? br : 1'($urandom);
      imem_ack    = spur && (j != rd);
      imem_rdata  = ~d;
      br_valid    = spur && (j == rd);
      br_taken    = 1'b1;
      @(negedge clk);
    end
    o_instr = first;
    instr_ready = 1'b0; is_branch = 1'b0; imem_ack = 1'b0; br_valid = 1'b0;
    if (br) begin
      for (int k = 0; k <= bd; k++) begin
        o_cyc++;
        if (state_o !== 3'd3) o_bad++;
        if (pc_en !== 1'b0 || pc_src !== 1'b0) o_early++;
        br_valid = (k == bd);
        br_taken = (k == bd) ? tk : ~tk;
        @(negedge clk);
      end
      br_valid = 1'b0;
    end
    o_cyc++;
    if (state_o !== 3'd4) o_bad++;
    o_pen = int'(pc_en);
    o_src = pc_src;
    imem_ack = spur;
    @(negedge clk);
    imem_ack = 1'b0;
    o_next = state_o;
    if (pc_en !== 1'b0) o_early++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({state_o, imem_req, instr_valid, pc_en, pc_src, fault, instr} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got state=%0d req=%b val=%b en=%b src=%b flt=%b instr=%h want all 0",
               state_o, imem_req, instr_valid, pc_en, pc_src, fault, instr);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (state_o !== 3'd1 || imem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_bubble: got state=%0d req=%b want 1/1", state_o, imem_req);
    end
  endtask

  task automatic test_stream();
    logic [31:0] e_i;
    logic        e_s;
    for (int n = 0; n < 4; n++) begin
      drive_instr(32'h0000_0013 + 32'(n) * 32'h100, 0, 0, 1'b0, 0, 1'b0, 1'b0);
      e_i = sb_instr.pop_front();
      e_s = sb_src.pop_front();
      n_cmp++;
      if (o_instr !== e_i) begin
        n_bad++; $display("FAIL stream_instr: got %h want %h", o_instr, e_i);
      end
      n_cmp++;
      if (o_cyc !== 3 || o_bad !== 0 || o_next !== 3'd1) begin
        n_bad++;
        $display("FAIL stream_seq: got cyc=%0d bad=%0d next=%0d want 3/0/1", o_cyc, o_bad, o_next);
      end
      n_cmp++;
      if (o_pen !== 1 || o_src !== e_s || o_early !== 0) begin
        n_bad++;
        $display("FAIL stream_pc: got en=%0d src=%b extra=%0d want 1/%b/0", o_pen, o_src, o_early, e_s);
      end
    end
  endtask

  task automatic test_branch();
    logic [31:0] e_i;
    logic        e_s;
    for (int n = 0; n < 2; n++) begin
      drive_instr(32'hB000_0063 ^ 32'(n), 0, 0, 1'b1, 3, (n == 0), 1'b0);
      e_i = sb_instr.pop_front();
      e_s = sb_src.pop_front();
      n_cmp++;
      if (o_instr !== e_i) begin
        n_bad++; $display("FAIL branch_instr: got %h want %h", o_instr, e_i);
      end
      n_cmp++;
      if (o_cyc !== 7 || o_bad !== 0 || o_next !== 3'd1) begin
        n_bad++;
        $display("FAIL branch_seq: got cyc=%0d bad=%0d next=%0d want 7/0/1", o_cyc, o_bad, o_next);
      end
      n_cmp++;
      if (o_pen !== 1 || o_src !== e_s || o_early !== 0) begin
        n_bad++;
        $display("FAIL branch_pc: got en=%0d src=%b extra=%0d want 1/%b/0", o_pen, o_src, o_early, e_s);
      end
    end
    drive_instr(32'h0000_0033, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    e_i = sb_instr.pop_front();
    e_s = sb_src.pop_front();
    n_cmp++;
    if (o_pen !== 1 || o_src !== e_s || o_instr !== e_i) begin
      n_bad++;
      $display("FAIL after_branch: got en=%0d src=%b instr=%h want 1/%b/%h", o_pen, o_src, o_instr, e_s, e_i);
    end
  endtask

  task automatic test_latency();
    logic [31:0] e_i;
    logic        e_s;
    drive_instr(32'hCAFE_0093, 4, 4, 1'b0, 0, 1'b0, 1'b0);
    e_i = sb_instr.pop_front();
    e_s = sb_src.pop_front();
    n_cmp++;
    if (o_req !== 5) begin
      n_bad++; $display("FAIL latency_req: got %0d cycles want 5", o_req);
    end
    n_cmp++;
    if (o_instr !== e_i || o_stable !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_hold: got instr=%h stable=%b want %h/1", o_instr, o_stable, e_i);
    end
    n_cmp++;
    if (o_cyc !== 11 || o_bad !== 0 || o_pen !== 1 || o_src !== e_s || o_early !== 0) begin
      n_bad++;
      $display("FAIL latency_seq: got cyc=%0d bad=%0d en=%0d src=%b extra=%0d want 11/0/1/%b/0",
               o_cyc, o_bad, o_pen, o_src, o_early, e_s);
    end
  endtask

  task automatic test_spurious();
    logic [31:0] e_i;
    logic        e_s;
    drive_instr(32'h5A5A_0013, 2, 3, 1'b0, 0, 1'b0, 1'b1);
    e_i = sb_instr.pop_front();
    e_s = sb_src.pop_front();
    n_cmp++;
    if (o_instr !== e_i || o_stable !== 1'b1) begin
      n_bad++;
      $display("FAIL spur_instr: got instr=%h stable=%b want %h/1", o_instr, o_stable, e_i);
    end
    n_cmp++;
    if (o_cyc !== 8 || o_bad !== 0 || o_pen !== 1 || o_src !== e_s || o_early !== 0) begin
      n_bad++;
      $display("FAIL spur_nb: got cyc=%0d bad=%0d en=%0d src=%b extra=%0d want 8/0/1/%b/0",
               o_cyc, o_bad, o_pen, o_src, o_early, e_s);
    end
    drive_instr(32'h5A5A_0063, 1, 2, 1'b1, 2, 1'b0, 1'b1);
    e_i = sb_instr.pop_front();
    e_s = sb_src.pop_front();
    n_cmp++;
    if (o_instr !== e_i || o_cyc !== 9 || o_bad !== 0 || o_pen !== 1 || o_src !== e_s || o_early !== 0) begin
      n_bad++;
      $display("FAIL spur_br: got instr=%h cyc=%0d bad=%0d en=%0d src=%b extra=%0d want %h/9/0/1/%b/0",
               o_instr, o_cyc, o_bad, o_pen, o_src, o_early, e_i, e_s);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e_i;
    logic        e_s;
    imem_ack = 1'b1; imem_rdata = 32'h1234_0063;
    @(negedge clk);
    imem_ack = 1'b0; instr_ready = 1'b1; is_branch = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; is_branch = 1'b0;
    n_cmp++;
    if (state_o !== 3'd3) begin
      n_bad++; $display("FAIL mid_resolve: got state=%0d want 3", state_o);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({state_o, imem_req, instr_valid, pc_en, pc_src, fault, instr} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got state=%0d req=%b val=%b en=%b src=%b flt=%b instr=%h want all 0",
               state_o, imem_req, instr_valid, pc_en, pc_src, fault, instr);
    end
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++;
    if (state_o !== 3'd1 || instr !== 32'h0) begin
      n_bad++; $display("FAIL mid_late_ack: got state=%0d instr=%h want 1/0", state_o, instr);
    end
    drive_instr(32'h7777_0013, 0, 0, 1'b0, 0, 1'b0, 1'b0);
    e_i = sb_instr.pop_front();
    e_s = sb_src.pop_front();
    n_cmp++;
    if (o_instr !== e_i || o_cyc !== 3 || o_pen !== 1 || o_src !== e_s) begin
      n_bad++;
      $display("FAIL mid_resume: got instr=%h cyc=%0d en=%0d src=%b want %h/3/1/%b",
               o_instr, o_cyc, o_pen, o_src, e_i, e_s);
    end
  endtask

`ifdef FETCH_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] e_i;
    logic        e_s;
    int          n;
    n = 0;
    for (int i = 0; i < 30 && state_o === 3'd1; i++) begin
      if (imem_req === 1'b1) n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 15) begin
      n_bad++; $display("FAIL timeout_len: got %0d fetch cycles want 15", n);
    end
    n_cmp++;
    if (state_o !== 3'd5 || fault !== 1'b1 || imem_req !== 1'b0 || instr_valid !== 1'b0 || pc_en !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_halt: got state=%0d flt=%b req=%b want 5/1/0", state_o, fault, imem_req);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    n_cmp++;
    if (state_o !== 3'd5 || fault !== 1'b1) begin
      n_bad++; $display("FAIL timeout_sticky: got state=%0d flt=%b want 5/1", state_o, fault);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (state_o !== 3'd0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL timeout_clear: got state=%0d flt=%b want 0/0", state_o, fault);
    end
    @(negedge clk);
    drive_instr(32'hACED_0013, 14, 0, 1'b0, 0, 1'b0, 1'b0);
    e_i = sb_instr.pop_front();
    e_s = sb_src.pop_front();
    n_cmp++;
    if (o_req !== 15 || o_bad !== 0 || fault !== 1'b0 || o_instr !== e_i || o_src !== e_s) begin
      n_bad++;
      $display("FAIL timeout_ack_wins: got req=%0d bad=%0d flt=%b instr=%h want 15/0/0/%h",
               o_req, o_bad, fault, o_instr, e_i);
    end
  endtask
`else
  task automatic test_timeout();
    logic [31:0] e_i;
    logic        e_s;
    drive_instr(32'hACED_0013, 40, 0, 1'b0, 0, 1'b0, 1'b0);
    e_i = sb_instr.pop_front();
    e_s = sb_src.pop_front();
    n_cmp++;
    if (o_req !== 41 || o_bad !== 0 || fault !== 1'b0) begin
      n_bad++;
      $display("FAIL no_timeout: got req=%0d bad=%0d flt=%b want 41/0/0", o_req, o_bad, fault);
    end
    n_cmp++;
    if (o_instr !== e_i || o_pen !== 1 || o_src !== e_s) begin
      n_bad++;
      $display("FAIL no_timeout_instr: got instr=%h en=%0d want %h/1", o_instr, o_pen, e_i);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_branch();
    test_latency();
    test_spurious();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
